// File: rtl/nios2_system_v0_led_blink_pio.sv
// LED output PIO with atomic set/clear registers and per-bit hardware blink.
// Avalon-MM slave: single-cycle writes, combinational reads, no wait states.
module nios2_system_v0_led_blink_pio #(
    parameter int WIDTH        = 8,
    parameter int PRESCALE_W   = 24,
    parameter int RESET_PERIOD = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK    = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    localparam logic [PRESCALE_W-1:0] RESET_PERIOD_C = PRESCALE_W'(RESET_PERIOD);
    localparam logic [PRESCALE_W-1:0] ONE_C          = PRESCALE_W'(1);

    logic                  wr_s;
    logic [WIDTH-1:0]      wd_bits_s;
    logic [PRESCALE_W-1:0] wd_period_s;
    logic                  unused_wd_s;
    logic [WIDTH-1:0]      data_r;
    logic [WIDTH-1:0]      blink_r;
    logic [PRESCALE_W-1:0] period_r;
    logic [PRESCALE_W-1:0] cnt_r;
    logic                  phase_r;

    assign wr_s        = chipselect & ~write_n;
    assign wd_bits_s   = writedata[WIDTH-1:0];
    assign wd_period_s = writedata[PRESCALE_W-1:0];
    assign unused_wd_s = ^writedata;

    // Output data register, including the atomic set/clear aliases.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r <= '0;
        end else if (wr_s && address == ADDR_DATA) begin
            data_r <= wd_bits_s;
        end else if (wr_s && address == ADDR_OUTSET) begin
            data_r <= data_r | wd_bits_s;
        end else if (wr_s && address == ADDR_OUTCLEAR) begin
            data_r <= data_r & ~wd_bits_s;
        end else begin
            data_r <= data_r;
        end
    end

    // Per-bit blink enable; deliberately leaves the prescaler untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_r <= '0;
        end else if (wr_s && address == ADDR_BLINK) begin
            blink_r <= wd_bits_s;
        end else begin
            blink_r <= blink_r;
        end
    end

    // Prescaler: a PERIOD write restarts the count and wins over an expiry on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_r <= RESET_PERIOD_C;
            cnt_r    <= RESET_PERIOD_C;
            phase_r  <= 1'b0;
        end else if (wr_s && address == ADDR_PERIOD) begin
            period_r <= wd_period_s;
            cnt_r    <= wd_period_s;
            phase_r  <= 1'b0;
        end else if (period_r == '0) begin
            period_r <= period_r;
            cnt_r    <= cnt_r;
            phase_r  <= phase_r;
        end else if (cnt_r == '0) begin
            period_r <= period_r;
            cnt_r    <= period_r;
            phase_r  <= ~phase_r;
        end else begin
            period_r <= period_r;
            cnt_r    <= cnt_r - ONE_C;
            phase_r  <= phase_r;
        end
    end

    // Combinational register readback, zero-extended to the bus width.
    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_DATA:   readdata = 32'(data_r);
            ADDR_BLINK:  readdata = 32'(blink_r);
            ADDR_PERIOD: readdata = 32'(period_r);
            ADDR_STATUS: readdata = {31'd0, phase_r};
            default:     readdata = 32'd0;
        endcase
    end

    // Blinking bits are lit in phase 0 and dark in phase 1.
    always_comb begin
        out_port = data_r & ~(blink_r & {WIDTH{phase_r}});
    end

endmodule
